sr_latch_ctrl: RTL and testbench
================================

SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

Interface
- REQ-001: Parameter PULSE_CYC, default 2: cycles the selected latch input is driven low; legal range 1..15.
- REQ-002: Parameter SETTLE_CYC, default 1: cycles both latch inputs are held high after a pulse, before acknowledge; legal range 1..15.
- REQ-003: Port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-004: Port rst_n, input, 1: asynchronous, active-low reset.
- REQ-005: Port set_req_a / clr_req_a, input, 1 each: requester A asks to set or clear the latch; held until ack_a.
- REQ-006: Port set_req_b / clr_req_b, input, 1 each: requester B, same rules as A.
- REQ-007: Port ack_a / ack_b, output, 1 each: one-cycle completion pulse to the granted requester.
- REQ-008: Port set_n / reset_n, output, 1 each: active-low drive to the NAND SR latch; idle high.
- REQ-009: Port q, input, 1: latch output fed back to the controller.
- REQ-010: Port busy, output, 1: high in every state except IDLE.
- REQ-011: Port err, output, 1: sticky error flag.

Function
- REQ-012: FSM states: IDLE, PULSE, SETTLE, ACK.
- REQ-013: IDLE: a requester is pending when its set_req or clr_req is high; the arbiter grants one pending requester and moves to PULSE on the next edge.
- REQ-014: Arbitration is round-robin: if both are pending, the requester not granted last wins; after reset, A has priority.
- REQ-015: PULSE: a set grant drives set_n=0, and a clear grant drives reset_n=0, for exactly PULSE_CYC cycles; the other input stays high.
- REQ-016: set_n and reset_n are never low in the same cycle; this protects the forbidden NAND state.
- REQ-017: SETTLE: set_n=1 and reset_n=1 for SETTLE_CYC cycles, then move to ACK.
- REQ-018: ACK: assert the granted requester's ack for one cycle, then return to IDLE.
- REQ-019: Latency from grant edge to ack high is PULSE_CYC+SETTLE_CYC+1 cycles.
- REQ-020: If the granted requester has set_req and clr_req both high, it is an invalid command:
  - no pulse is generated (PULSE and SETTLE are skipped);
  - err is set to 1;
  - ack is still issued in the following cycle.
- REQ-021: The command (set or clear) is latched at grant; request changes after grant are ignored until ack.
- REQ-022: A request still high in the cycle after its ack is treated as a new request.
- REQ-023: err stays at 1 until reset.
- REQ-024: The pulse counter is 4 bits and does not wrap; it reloads at each PULSE or SETTLE entry.

Reset
- REQ-025: While rst_n=0, immediately and independently of clk: set_n=1, reset_n=1, ack_a=0, ack_b=0, busy=0, err=0, state=IDLE, round-robin pointer=A.
- REQ-026: A reset asserted mid-PULSE releases the latch input within the same cycle; the latch keeps its last value.
- REQ-027: A pending request that has not been acknowledged when reset is asserted is dropped.

Configuration
- REQ-028: Macro SR_LATCH_CTRL_VERIFY_EN defined: in ACK, compare q with the latched command (set expects q=1, clear expects q=0) and set err on mismatch.
- REQ-029: Macro SR_LATCH_CTRL_VERIFY_EN undefined: q is unused and err is set only by invalid commands.

Verification
- REQ-030: Defaults; set_req_a=1 from IDLE -> set_n low for 2 cycles, ack_a high 4 cycles after grant, q=1, err=0.
- REQ-031: set_req_a=1 and clr_req_b=1 asserted in the same cycle after reset -> A is served first (q=1), then B (q=0); ack_a precedes ack_b by 4 cycles.
- REQ-032: Both requesters hold requests continuously for 4 grants -> grant order A, B, A, B; set_n and reset_n are never both 0.
- REQ-033: set_req_b=1 and clr_req_b=1 together -> no pulse, ack_b one cycle after grant, err=1 and held until rst_n=0.
- REQ-034: rst_n=0 asserted in the second PULSE cycle -> set_n=1 and busy=0 immediately, no ack, and q holds its prior value.
- REQ-035: With SR_LATCH_CTRL_VERIFY_EN defined, q forced to 0 during a set command -> err=1 in the ACK cycle.

Source files
------------

// File: rtl/sr_latch_ctrl_if.sv
// ---------------------------------------------------------------------------
// sr_latch_ctrl_if
// Groups the requester handshake and the NAND SR latch drive/feedback of
// sr_latch_ctrl into one bundle.
//   set_req_a / clr_req_a : requester A set/clear request (held until ack_a)
//   set_req_b / clr_req_b : requester B set/clear request (held until ack_b)
//   ack_a / ack_b         : one-cycle completion pulse to the granted requester
//   set_n / reset_n       : active-low drive into the NAND latch, idle high
//   q                     : latch output fed back to the controller
//   busy                  : controller is not idle
//   err                   : sticky error flag
// modport master : requesters plus the latch (drives requests and q)
// modport slave  : the controller
// ---------------------------------------------------------------------------
interface sr_latch_ctrl_if;
   logic set_req_a;
   logic clr_req_a;
   logic set_req_b;
   logic clr_req_b;
   logic ack_a;
   logic ack_b;
   logic set_n;
   logic reset_n;
   logic q;
   logic busy;
   logic err;

   modport master (
      output set_req_a, clr_req_a, set_req_b, clr_req_b, q,
      input  ack_a, ack_b, set_n, reset_n, busy, err
   );

   modport slave (
      input  set_req_a, clr_req_a, set_req_b, clr_req_b, q,
      output ack_a, ack_b, set_n, reset_n, busy, err
   );
endinterface

// File: rtl/sr_latch_ctrl.sv
// ---------------------------------------------------------------------------
// sr_latch_ctrl
// Controller for an external NAND SR latch shared by two requesters (A, B).
// A round-robin arbiter grants one requester; the controller then drives the
// selected latch input low for PULSE_CYC cycles, holds both inputs high for
// SETTLE_CYC cycles and pulses the granted requester's ack for one cycle.
// A request with set and clear both high is rejected: no pulse, err set,
// ack issued in the cycle right after the grant.
//
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sr_latch_ctrl_if.slave (requests, acks, latch drive, q, busy, err)
// Parameters
//   PULSE_CYC  : cycles the selected latch input is low (1..15)
//   SETTLE_CYC : cycles both inputs are high before ack (1..15)
// Configuration
//   SR_LATCH_CTRL_VERIFY_EN : when defined, q is compared against the latched
//   command when ACK is entered and a mismatch sets err. When undefined, q is
//   ignored and err is set only by invalid commands.
//
// Timing: counting the cycle after the grant edge as cycle 1, a valid command
// acks in cycle PULSE_CYC+SETTLE_CYC+1, an invalid one in cycle 1. All outputs
// are registered from the next-state value, so they line up with the state.
// ---------------------------------------------------------------------------
module sr_latch_ctrl #(
   parameter int unsigned PULSE_CYC  = 2,
   parameter int unsigned SETTLE_CYC = 1
) (
   input logic            clk,
   input logic            rst_n,
   sr_latch_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PULSE  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_ACK    = 2'd3
   } state_e;

   // The counter holds "cycles left minus one" so it reaches zero in the
   // last cycle of the phase and never has to wrap.
   localparam logic [3:0] PULSE_LOAD  = 4'(PULSE_CYC - 32'd1);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 32'd1);

   state_e     state_q,   state_d;
   logic [3:0] cnt_q,     cnt_d;
   logic       cmd_set_q, cmd_set_d;  // latched command: 1 = set, 0 = clear
   logic       gnt_b_q,   gnt_b_d;    // granted requester: 1 = B, 0 = A
   logic       prio_b_q,  prio_b_d;   // round-robin pointer: 1 = B wins a tie
   logic       err_q,     err_d;
   logic       set_n_q,   set_n_d;
   logic       reset_n_q, reset_n_d;
   logic       ack_a_q,   ack_a_d;
   logic       ack_b_q,   ack_b_d;
   logic       busy_q,    busy_d;

   logic pend_a;
   logic pend_b;
   logic pick_b;
   logic pick_set;
   logic pick_clr;
   logic q_mismatch;

`ifdef SR_LATCH_CTRL_VERIFY_EN
   // In the last SETTLE cycle q already shows the final latch value.
   assign q_mismatch = (bus.q != cmd_set_q);
`else
   logic unused_q;
   assign unused_q   = bus.q;
   assign q_mismatch = 1'b0;
`endif

   // Round-robin arbitration between the two requesters
   always_comb begin
      pend_a = bus.set_req_a | bus.clr_req_a;
      pend_b = bus.set_req_b | bus.clr_req_b;
      pick_b = pend_b & (~pend_a | prio_b_q);
      if (pick_b) begin
         pick_set = bus.set_req_b;
         pick_clr = bus.clr_req_b;
      end else begin
         pick_set = bus.set_req_a;
         pick_clr = bus.clr_req_a;
      end
   end

   // Next-state, counter, command latch and output decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cmd_set_d = cmd_set_q;
      gnt_b_d   = gnt_b_q;
      prio_b_d  = prio_b_q;
      err_d     = err_q;

      case (state_q)
         ST_IDLE: begin
            if (pend_a | pend_b) begin
               gnt_b_d   = pick_b;
               prio_b_d  = ~pick_b;
               cmd_set_d = pick_set;
               if (pick_set & pick_clr) begin
                  // Invalid command: skip the pulse, flag it, still ack.
                  state_d = ST_ACK;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_PULSE;
                  cnt_d   = PULSE_LOAD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PULSE: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_SETTLE;
               cnt_d   = SETTLE_LOAD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_ACK;
               err_d   = err_q | q_mismatch;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Only one latch input can ever be low: both derive from the single
      // PULSE state, split by the one latched command bit.
      set_n_d   = ~((state_d == ST_PULSE) &  cmd_set_d);
      reset_n_d = ~((state_d == ST_PULSE) & ~cmd_set_d);
      ack_a_d   = (state_d == ST_ACK) & ~gnt_b_d;
      ack_b_d   = (state_d == ST_ACK) &  gnt_b_d;
      busy_d    = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset releases the latch inputs at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         cmd_set_q <= 1'b0;
         gnt_b_q   <= 1'b0;
         prio_b_q  <= 1'b0;
         err_q     <= 1'b0;
         set_n_q   <= 1'b1;
         reset_n_q <= 1'b1;
         ack_a_q   <= 1'b0;
         ack_b_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cmd_set_q <= cmd_set_d;
         gnt_b_q   <= gnt_b_d;
         prio_b_q  <= prio_b_d;
         err_q     <= err_d;
         set_n_q   <= set_n_d;
         reset_n_q <= reset_n_d;
         ack_a_q   <= ack_a_d;
         ack_b_q   <= ack_b_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.set_n   = set_n_q;
   assign bus.reset_n = reset_n_q;
   assign bus.ack_a   = ack_a_q;
   assign bus.ack_b   = ack_b_q;
   assign bus.busy    = busy_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sr_latch_ctrl
// Bench for sr_latch_ctrl with default parameters. A behavioural NAND latch
// closes the loop on q. Expected transactions are queued when requests are
// driven; a monitor pops one per ack and checks requester, latency, pulse
// widths, q and err. Define SR_LATCH_CTRL_VERIFY_EN to add the q-check case.
// ---------------------------------------------------------------------------
module tb_sr_latch_ctrl;
   localparam int P = 2;
   localparam int S = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   sr_latch_ctrl_if bus ();

   sr_latch_ctrl #(.PULSE_CYC(P), .SETTLE_CYC(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural NAND latch; q_stuck models a latch that fails to set.
   logic latch_v = 1'b0;
   logic q_stuck = 1'b0;
   always @(bus.set_n or bus.reset_n) begin
      if (bus.set_n === 1'b0)        latch_v = 1'b1;
      else if (bus.reset_n === 1'b0) latch_v = 1'b0;
   end
   assign bus.q = q_stuck ? 1'b0 : latch_v;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   typedef struct {
      bit is_b;
      bit is_set;
      bit invalid;
      bit bad_q;
   } exp_t;

   exp_t exp_q[$];
   int   ack_cyc[$];
   bit   exp_latch = 1'b0;
   bit   exp_err   = 1'b0;

   task automatic push_exp(input bit b, input bit s, input bit inv, input bit bq);
      exp_t e;
      e.is_b = b; e.is_set = s; e.invalid = inv; e.bad_q = bq;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: measures each transaction from busy rising to ack
   int cyc = 0;
   int k = 0;
   int sn_low = 0;
   int rn_low = 0;
   bit in_txn = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         exp_err = 1'b0;
         in_txn  = 1'b0;
      end else begin
         check_val("nand_excl", {31'd0, (~bus.set_n & ~bus.reset_n)}, 32'd0);
         if (bus.busy) begin
            if (!in_txn) begin
               in_txn = 1'b1; k = 0; sn_low = 0; rn_low = 0;
            end
            k++;
            if (!bus.set_n)   sn_low++;
            if (!bus.reset_n) rn_low++;
            if (bus.ack_a || bus.ack_b) begin
               in_txn = 1'b0;
               ack_cyc.push_back(cyc);
               check_val("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  if (!e.invalid) exp_latch = e.is_set;
                  exp_err = exp_err | e.invalid | e.bad_q;
                  check_val("ack_b", {31'd0, bus.ack_b}, {31'd0, e.is_b});
                  check_val("ack_a", {31'd0, bus.ack_a}, {31'd0, ~e.is_b});
                  check_val("latency", k, e.invalid ? 1 : P + S + 1);
                  check_val("set_n_low", sn_low, (!e.invalid && e.is_set) ? P : 0);
                  check_val("reset_n_low", rn_low, (!e.invalid && !e.is_set) ? P : 0);
                  check_val("q", {31'd0, bus.q}, {31'd0, (e.bad_q ? 1'b0 : exp_latch)});
                  check_val("err", {31'd0, bus.err}, {31'd0, exp_err});
               end
            end
         end else begin
            in_txn = 1'b0;
         end
      end
   end

   task automatic wait_ack(input bit want_b, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(want_b ? bus.ack_b : bus.ack_a) && n < 60);
      check_val({tag, "_ack_seen"}, {31'd0, (want_b ? bus.ack_b : bus.ack_a)}, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int n;
      bus.set_req_a = 1'b0; bus.clr_req_a = 1'b0;
      bus.set_req_b = 1'b0; bus.clr_req_b = 1'b0;

      // Reset state, checked before any clock edge
      #1 rst_n = 1'b0;
      #2;
      check_val("rst_set_n",   {31'd0, bus.set_n},   32'd1);
      check_val("rst_reset_n", {31'd0, bus.reset_n}, 32'd1);
      check_val("rst_ack_a",   {31'd0, bus.ack_a},   32'd0);
      check_val("rst_ack_b",   {31'd0, bus.ack_b},   32'd0);
      check_val("rst_busy",    {31'd0, bus.busy},    32'd0);
      check_val("rst_err",     {31'd0, bus.err},     32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single set from A
      push_exp(1'b0, 1'b1, 1'b0, 1'b0);
      bus.set_req_a = 1'b1;
      wait_ack(1'b0, "t1");
      bus.set_req_a = 1'b0;
      @(negedge clk);

      // A set and B clear together after reset: A first, then B
      do_reset();
      ack_cyc.delete();
      push_exp(1'b0, 1'b1, 1'b0, 1'b0);
      push_exp(1'b1, 1'b0, 1'b0, 1'b0);
      bus.set_req_a = 1'b1;
      bus.clr_req_b = 1'b1;
      wait_ack(1'b0, "t2a");
      bus.set_req_a = 1'b0;
      wait_ack(1'b1, "t2b");
      bus.clr_req_b = 1'b0;
      @(negedge clk);
      check_val("t2_ack_count", ack_cyc.size(), 2);
      // ack_a cycle, IDLE, P pulse cycles, S settle cycles, then ack_b:
      // four cycles lie strictly between the two acks.
      if (ack_cyc.size() == 2)
         check_val("t2_ack_spacing", ack_cyc[1] - ack_cyc[0], P + S + 2);

      // Both requesters held continuously: A, B, A, B
      push_exp(1'b0, 1'b1, 1'b0, 1'b0);
      push_exp(1'b1, 1'b0, 1'b0, 1'b0);
      push_exp(1'b0, 1'b1, 1'b0, 1'b0);
      push_exp(1'b1, 1'b0, 1'b0, 1'b0);
      bus.set_req_a = 1'b1;
      bus.clr_req_b = 1'b1;
      wait_ack(1'b0, "t3_1");
      wait_ack(1'b1, "t3_2");
      wait_ack(1'b0, "t3_3");
      wait_ack(1'b1, "t3_4");
      bus.set_req_a = 1'b0;
      bus.clr_req_b = 1'b0;
      @(negedge clk);

      // Invalid command from B: no pulse, immediate ack, sticky err
      push_exp(1'b1, 1'b0, 1'b1, 1'b0);
      bus.set_req_b = 1'b1;
      bus.clr_req_b = 1'b1;
      wait_ack(1'b1, "t4");
      bus.set_req_b = 1'b0;
      bus.clr_req_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("t4_err_sticky", {31'd0, bus.err}, 32'd1);
      end
      rst_n = 1'b0;
      #1;
      check_val("t4_err_cleared", {31'd0, bus.err}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset in the second PULSE cycle of a set (latch was cleared before)
      bus.set_req_a = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.busy && n < 20);
      check_val("t5_busy_seen", {31'd0, bus.busy}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("t5_set_n",   {31'd0, bus.set_n},   32'd1);
      check_val("t5_reset_n", {31'd0, bus.reset_n}, 32'd1);
      check_val("t5_busy",    {31'd0, bus.busy},    32'd0);
      check_val("t5_ack_a",   {31'd0, bus.ack_a},   32'd0);
      // The first pulse cycle already set the latch; reset must leave it set.
      check_val("t5_q_hold",  {31'd0, bus.q},       32'd1);
      bus.set_req_a = 1'b0;
      repeat (3) @(negedge clk);
      check_val("t5_q_stable", {31'd0, bus.q}, 32'd1);
      exp_latch = 1'b1;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_val("t5_dropped_busy", {31'd0, bus.busy},  32'd0);
      check_val("t5_dropped_ack",  {31'd0, bus.ack_a}, 32'd0);

`ifdef SR_LATCH_CTRL_VERIFY_EN
      // Latch refuses to set: q stays 0, err must rise with the ack
      q_stuck = 1'b1;
      push_exp(1'b0, 1'b1, 1'b0, 1'b1);
      bus.set_req_a = 1'b1;
      wait_ack(1'b0, "t6");
      bus.set_req_a = 1'b0;
      @(negedge clk);
      q_stuck = 1'b0;
`endif

      @(negedge clk);
      check_val("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
